// File: rtl/sysa_seq.sv
// sysa_seq: job sequencer for a 3x3 weight-stationary systolic array.
// It loads 9 weights (or reuses the stored set), loads 3 input rows, feeds
// them to the array with a diagonal skew for 7 cycles, captures the column
// outputs into a 9-entry result buffer, then drains the buffer over a
// valid/ready stream and pulses done.
module sysa_seq #(
  parameter int DW = 8,
  parameter int AW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            keep_w,
  output logic            busy,
  output logic            done,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [DW-1:0]   w_data,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic [3*DW-1:0] x_data,
  output logic            sa_en,
  output logic [9*DW-1:0] sa_w,
  output logic [3*DW-1:0] sa_in,
  input  logic [AW-1:0]   sa_out1,
  input  logic [AW-1:0]   sa_out2,
  input  logic [AW-1:0]   sa_out3,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [AW-1:0]   r_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // Last counter value in each counted state.
  localparam logic [3:0] LAST_W   = 4'd8;
  localparam logic [3:0] LAST_X   = 4'd2;
  localparam logic [3:0] LAST_RUN = 4'd6;
  localparam logic [3:0] LAST_R   = 4'd8;

  state_t          r_state;
  state_t          w_state_nxt;
  // Shared counter: weight beat, row beat, RUN cycle t or drain index,
  // depending on the state. Cleared on every state change.
  logic [3:0]      r_cnt;
  logic            r_w_vld;
  logic [9*DW-1:0] r_sa_w;
  logic [3*DW-1:0] r_rows [3];
  logic [AW-1:0]   r_res  [9];
  logic            w_beat;
  logic            w_last;

  // Next-state logic and handshake/status outputs, decoded from the state.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path can leave a signal unassigned and infer a latch.
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    w_last      = 1'b0;
    busy        = (r_state != S_IDLE);
    done        = 1'b0;
    w_ready     = 1'b0;
    x_ready     = 1'b0;
    sa_en       = 1'b0;
    r_valid     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (keep_w && r_w_vld) ? S_LOAD_X : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        w_ready = 1'b1;
        w_beat  = w_valid;
        w_last  = (r_cnt == LAST_W);
        if (w_beat && w_last) w_state_nxt = S_LOAD_X;
      end
      S_LOAD_X: begin
        x_ready = 1'b1;
        w_beat  = x_valid;
        w_last  = (r_cnt == LAST_X);
        if (w_beat && w_last) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        sa_en  = 1'b1;
        w_beat = 1'b1;
        w_last = (r_cnt == LAST_RUN);
        if (w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        r_valid = 1'b1;
        w_beat  = r_ready;
        w_last  = (r_cnt == LAST_R);
        if (w_beat && w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and shared beat/cycle counter.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) begin
        r_cnt <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  // Weight store; the valid flag is dropped as soon as a reload begins so
  // a partially overwritten set is never reused.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sa_w  <= '0;
      r_w_vld <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_state_nxt == S_LOAD_W) begin
        r_w_vld <= 1'b0;
      end
      if (r_state == S_LOAD_W && w_valid) begin
        for (int n = 0; n < 9; n++) begin
          if (r_cnt == 4'(n)) r_sa_w[n*DW +: DW] <= w_data;
        end
        if (r_cnt == LAST_W) r_w_vld <= 1'b1;
      end
    end
  end

  // Input row store, one row per accepted beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 3; r++) r_rows[r] <= '0;
    end else if (r_state == S_LOAD_X && x_valid) begin
      for (int r = 0; r < 3; r++) begin
        if (r_cnt == 4'(r)) r_rows[r] <= x_data;
      end
    end
  end

  // Result capture: each column output is valid for three consecutive RUN
  // cycles, one cycle later per column because of the input skew.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the 9-entry buffer is small and must read as zero after
      // reset, so it is cleared here rather than left as uninitialised RAM.
      for (int i = 0; i < 9; i++) r_res[i] <= '0;
    end else if (r_state == S_RUN) begin
      case (r_cnt)
        4'd1: begin
          r_res[0] <= sa_out1;
        end
        4'd2: begin
          r_res[1] <= sa_out1;
          r_res[3] <= sa_out2;
        end
        4'd3: begin
          r_res[2] <= sa_out1;
          r_res[4] <= sa_out2;
          r_res[6] <= sa_out3;
        end
        4'd4: begin
          r_res[5] <= sa_out2;
          r_res[7] <= sa_out3;
        end
        4'd5: begin
          r_res[8] <= sa_out3;
        end
        default: ;
      endcase
    end
  end

  // Skewed array feed: lane k carries row (t-k), so row r reaches lane k
  // at RUN cycle t = r + k.
  always_comb begin
    sa_in = '0;
    if (r_state == S_RUN) begin
      for (int k = 0; k < 3; k++) begin
        for (int r = 0; r < 3; r++) begin
          if (r_cnt == 4'(r + k)) sa_in[k*DW +: DW] = r_rows[r][k*DW +: DW];
        end
      end
    end
  end

  // Result stream data: the indexed entry, held while the drain index waits.
  always_comb begin
    r_data = '0;
    if (r_state == S_DRAIN) begin
      for (int i = 0; i < 9; i++) begin
        if (r_cnt == 4'(i)) r_data = r_res[i];
      end
    end
  end

  assign sa_w = r_sa_w;

endmodule
